// File: rtl/cache_refill_controller.sv
// ---------------------------------------------------------------------------------------------
// cache_refill_controller
//
// Sequences line refills for a set-associative cache and brokers all traffic into the
// replacement_policy block. On a miss it takes a victim way from the policy, fetches the line
// one 32-bit word at a time from memory, writes the data and tag arrays, and then pulses
// miss_done. Lookup hits are forwarded to the policy as read/written pulses, but only in
// cycles where the policy reports ready.
//
// Ports:
//   clk, reset                   clock (rising edge) and asynchronous active-low reset
//   hit_valid/write/set/way      hit notification from the lookup stage
//   hit_ready                    hit accepted this cycle
//   miss_valid/addr, miss_ready  refill request and its acceptance
//   miss_done, miss_way          one-cycle completion pulse and the victim way used
//   rp_set/way/read/written/taken, rp_replacement_way, rp_ready
//                                interface to the replacement_policy instance
//   mem_req/addr/gnt/rvalid/rdata  word read port towards memory
//   line_we/set/way/word/wdata   data array write port
//   tag_we, tag_wdata            tag array write port (also sets the valid bit)
// ---------------------------------------------------------------------------------------------
module cache_refill_controller #(
    parameter int unsigned WAY_COUNT      = 2,
    parameter int unsigned SET_COUNT      = 64,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    // Derived widths; not meant to be overridden.
    parameter int unsigned WAY_W  = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1,
    parameter int unsigned SET_W  = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
    parameter int unsigned WORD_W = $clog2(WORDS_PER_LINE),
    parameter int unsigned OFF    = WORD_W + 2,
    parameter int unsigned TAG_W  = ADDR_WIDTH - OFF - SET_W
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  hit_valid,
    input  logic                  hit_write,
    input  logic [SET_W-1:0]      hit_set,
    input  logic [WAY_W-1:0]      hit_way,
    output logic                  hit_ready,

    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  miss_ready,
    output logic                  miss_done,
    output logic [WAY_W-1:0]      miss_way,

    output logic [SET_W-1:0]      rp_set,
    output logic [WAY_W-1:0]      rp_way,
    output logic                  rp_read,
    output logic                  rp_written,
    output logic                  rp_taken,
    input  logic [WAY_W-1:0]      rp_replacement_way,
    input  logic                  rp_ready,

    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,

    output logic                  line_we,
    output logic [SET_W-1:0]      line_set,
    output logic [WAY_W-1:0]      line_way,
    output logic [WORD_W-1:0]     line_word,
    output logic [31:0]           line_wdata,
    output logic                  tag_we,
    output logic [TAG_W-1:0]      tag_wdata
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitRp,
        StIssue,
        StWaitData,
        StDone
    } state_t;

    localparam logic [WORD_W-1:0] LastWord = WORD_W'(WORDS_PER_LINE - 1);

    state_t                     state_q;
    logic [SET_W-1:0]           set_q;
    logic [TAG_W-1:0]           tag_q;
    // Line base without its (always zero) byte/word offset bits.
    logic [ADDR_WIDTH-OFF-1:0]  line_q;
    logic [WORD_W-1:0]          word_q;
    logic [WAY_W-1:0]           victim_q;

    logic accept_miss;

    // The byte/word offset of the missing address never matters: the whole line is fetched.
    logic unused_offset;
    assign unused_offset = ^miss_addr[OFF-1:0];

    // Hits take priority over a new miss in the same cycle.
    assign accept_miss = (state_q == StIdle) && miss_valid && !hit_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            set_q    <= '0;
            tag_q    <= '0;
            line_q   <= '0;
            word_q   <= '0;
            victim_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept_miss) begin
                        set_q   <= miss_addr[OFF +: SET_W];
                        tag_q   <= miss_addr[ADDR_WIDTH-1 -: TAG_W];
                        line_q  <= miss_addr[ADDR_WIDTH-1:OFF];
                        word_q  <= '0;
                        state_q <= StWaitRp;
                    end
                end
                StWaitRp: begin
                    if (rp_ready) begin
                        victim_q <= rp_replacement_way;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    if (mem_gnt) begin
                        state_q <= StWaitData;
                    end
                end
                StWaitData: begin
                    if (mem_rvalid) begin
                        if (word_q == LastWord) begin
                            state_q <= StDone;
                        end else begin
                            word_q  <= word_q + 1'b1;
                            state_q <= StIssue;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs are decoded from the state and, where the protocol demands a same-cycle
    // response, from the inputs. Reset gates everything so that an asserted reset silences
    // the block in the same cycle, even though some outputs follow inputs combinationally.
    always_comb begin
        hit_ready  = 1'b0;
        miss_ready = 1'b0;
        miss_done  = 1'b0;
        miss_way   = '0;
        rp_set     = '0;
        rp_way     = '0;
        rp_read    = 1'b0;
        rp_written = 1'b0;
        rp_taken   = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        line_we    = 1'b0;
        line_set   = '0;
        line_way   = '0;
        line_word  = '0;
        line_wdata = '0;
        tag_we     = 1'b0;
        tag_wdata  = '0;

        if (reset) begin
            rp_set = set_q;
            unique case (state_q)
                StIdle: begin
                    rp_set     = hit_set;
                    hit_ready  = rp_ready;
                    miss_ready = !hit_valid;
                    if (hit_valid && rp_ready) begin
                        rp_way     = hit_way;
                        rp_written = hit_write;
                        rp_read    = !hit_write;
                    end
                end
                StWaitRp: begin
                    // Victim is committed in the very cycle the policy offers it.
                    if (rp_ready) begin
                        rp_taken = 1'b1;
                        rp_way   = rp_replacement_way;
                    end
                end
                StIssue: begin
                    mem_req  = 1'b1;
                    mem_addr = {line_q, word_q, 2'b00};
                end
                StWaitData: begin
                    if (mem_rvalid) begin
                        line_we    = 1'b1;
                        line_set   = set_q;
                        line_way   = victim_q;
                        line_word  = word_q;
                        line_wdata = mem_rdata;
                    end
                end
                StDone: begin
                    tag_we    = 1'b1;
                    tag_wdata = tag_q;
                    miss_done = 1'b1;
                    miss_way  = victim_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
